// File: rtl/decode_queue_pkg.sv
// Shared RV32I encodings for the decode queue: opcodes, funct3/funct7 values
// and the instruction-format codes carried with every queued entry.
package decode_queue_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_SHIFT_I = 3'd6,
        FMT_NONE    = 3'd7
    } fmt_e;

endpackage

// File: rtl/decode_queue_imm.sv
// Combinational RV32I pre-decoder: classifies the format, flags illegal
// encodings and builds the sign-extended immediate.
module rv_imm_decode
    import decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immRaw;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        immRaw    = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                fmt_o  = FMT_U;
                immRaw = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o  = FMT_J;
                immRaw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                fmt_o     = FMT_I;
                immRaw    = {{20{instr_i[31]}}, instr_i[31:20]};
                illegal_o = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                fmt_o     = FMT_B;
                immRaw    = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
                illegal_o = (funct3 == F3_SLT) || (funct3 == F3_SLTU);
            end
            OPC_LOAD: begin
                fmt_o     = FMT_I;
                immRaw    = {{20{instr_i[31]}}, instr_i[31:20]};
                illegal_o = (funct3 == F3_SLTU) || (funct3 == F3_OR) || (funct3 == F3_AND);
            end
            OPC_STORE: begin
                fmt_o     = FMT_S;
                immRaw    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                illegal_o = (funct3 >= 3'd3);
            end
            OPC_ARI_ITYPE: begin
                // Shift amounts are unsigned and funct7 selects logical vs arithmetic.
                if (funct3 == F3_SLL) begin
                    fmt_o     = FMT_SHIFT_I;
                    immRaw    = {27'b0, instr_i[24:20]};
                    illegal_o = (funct7 != F7_BASE);
                end else if (funct3 == F3_SRL_SRA) begin
                    fmt_o     = FMT_SHIFT_I;
                    immRaw    = {27'b0, instr_i[24:20]};
                    illegal_o = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end else begin
                    fmt_o  = FMT_I;
                    immRaw = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OPC_ARI_RTYPE: begin
                fmt_o = FMT_R;
                if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
                    illegal_o = 1'b1;
                end else if ((funct7 == F7_ALT) &&
                             (funct3 != F3_ADD_SUB) && (funct3 != F3_SRL_SRA)) begin
                    illegal_o = 1'b1;
                end
            end
            OPC_FENCE: begin
                fmt_o = FMT_NONE;
            end
            OPC_CSR: begin
                fmt_o  = FMT_I;
                immRaw = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end
        if (illegal_o) begin
            immRaw = '0;
            fmt_o  = FMT_NONE;
        end
    end

    always_comb begin
        imm_o       = {XLEN{immRaw[31]}};
        imm_o[31:0] = immRaw;
    end

endmodule

// File: rtl/decode_queue.sv
// DEPTH-entry FIFO of pre-decoded RV32I instructions between fetch and
// register read, with valid/ready on both sides and a synchronous flush.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_funct3,
    output logic [6:0]               out_funct7,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [XLEN-1:0]          out_imm,
    output logic [2:0]               out_fmt,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PC_W-1:0]  pcMem_q    [DEPTH];
    logic [31:0]      instrMem_q [DEPTH];
    logic [XLEN-1:0]  immMem_q   [DEPTH];
    logic [2:0]       fmtMem_q   [DEPTH];
    logic             illMem_q   [DEPTH];

    logic [XLEN-1:0]  newImm;
    fmt_e             newFmt;
    logic             newIllegal;
    logic             doPush;
    logic             doPop;
    logic [31:0]      headInstr;

    rv_imm_decode #(
        .XLEN(XLEN)
    ) u_imm_decode (
        .instr_i  (in_instr),
        .imm_o    (newImm),
        .fmt_o    (newFmt),
        .illegal_o(newIllegal)
    );

    // in_ready looks only at occupancy, so a full queue never passes through.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign doPush    = in_valid && in_ready;
    assign doPop     = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
            else if (!doPush && doPop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            pcMem_q[wrPtr_q]    <= in_pc;
            instrMem_q[wrPtr_q] <= in_instr;
            immMem_q[wrPtr_q]   <= newImm;
            fmtMem_q[wrPtr_q]   <= newFmt;
            illMem_q[wrPtr_q]   <= newIllegal;
        end
    end

    // Storage is never reset, so the head is forced to zero while empty.
    assign headInstr   = out_valid ? instrMem_q[rdPtr_q] : '0;
    assign out_pc      = out_valid ? pcMem_q[rdPtr_q]    : '0;
    assign out_imm     = out_valid ? immMem_q[rdPtr_q]   : '0;
    assign out_fmt     = out_valid ? fmtMem_q[rdPtr_q]   : '0;
    assign out_illegal = out_valid ? illMem_q[rdPtr_q]   : 1'b0;
    assign out_opcode  = headInstr[6:0];
    assign out_rd      = headInstr[11:7];
    assign out_funct3  = headInstr[14:12];
    assign out_rs1     = headInstr[19:15];
    assign out_rs2     = headInstr[24:20];
    assign out_funct7  = headInstr[31:25];

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: table of decoded instructions plus
// hand-written full/flush/async-reset/wrap sequences.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int PC_W  = 32;
    localparam int NVEC  = 18;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;
    logic [2:0]        count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  rd;
    } vec_t;

    vec_t        vecs [NVEC];
    int          passCount;
    int          checkCount;
    int          expCount;
    int          pushed;
    int          popped;
    logic        wantPush;
    logic        wantPop;
    logic        drvValid;
    logic        drvReady;
    logic [31:0] pcQ [$];
    logic [31:0] pcVal;

    decode_queue #(
        .DEPTH(DEPTH),
        .XLEN (XLEN),
        .PC_W (PC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_funct3 (out_funct3),
        .out_funct7 (out_funct7),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [2:0] fmt, input logic ill);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_pc"}, out_pc, pc);
        checkOutput({tag, "_imm"}, out_imm, imm);
        checkOutput({tag, "_fmt"}, out_fmt, fmt);
        checkOutput({tag, "_illegal"}, out_illegal, ill);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 5'd1};
        vecs[1]  = '{32'h12345037, 32'h12345000, 3'd4, 1'b0, 5'd0};
        vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 5'd29};
        vecs[3]  = '{32'h00509113, 32'h00000005, 3'd6, 1'b0, 5'd2};
        vecs[4]  = '{32'h4050D113, 32'h00000005, 3'd6, 1'b0, 5'd2};
        vecs[5]  = '{32'h00000000, 32'h00000000, 3'd7, 1'b1, 5'd0};
        vecs[6]  = '{32'h0000707F, 32'h00000000, 3'd7, 1'b1, 5'd0};
        vecs[7]  = '{32'hFE512C23, 32'hFFFFFFF8, 3'd2, 1'b0, 5'd24};
        vecs[8]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 5'd1};
        vecs[9]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 5'd3};
        vecs[10] = '{32'h402091B3, 32'h00000000, 3'd7, 1'b1, 5'd3};
        vecs[11] = '{32'h000090E7, 32'h00000000, 3'd7, 1'b1, 5'd1};
        vecs[12] = '{32'h00412083, 32'h00000004, 3'd1, 1'b0, 5'd1};
        vecs[13] = '{32'h00413083, 32'h00000000, 3'd7, 1'b1, 5'd1};
        vecs[14] = '{32'hFFF00091, 32'h00000000, 3'd7, 1'b1, 5'd1};
        vecs[15] = '{32'hFFFFF017, 32'hFFFFF000, 3'd4, 1'b0, 5'd0};
        vecs[16] = '{32'h00002063, 32'h00000000, 3'd7, 1'b1, 5'd0};
        vecs[17] = '{32'h40009113, 32'h00000000, 3'd7, 1'b1, 5'd2};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_outValid", out_valid, 0);
        checkOutput("rst_inReady", in_ready, 1);
        checkOutput("rst_imm", out_imm, 0);
        checkOutput("rst_pc", out_pc, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First instruction: visible the cycle after its push edge.
        applyStimulus(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b0);
        checkHead("addi", 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0);
        checkOutput("addi_rd", out_rd, 1);
        checkOutput("addi_rs1", out_rs1, 0);
        checkOutput("addi_count", count, 1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("addi_popped", out_valid, 0);

        // Fill to DEPTH, then offer a push while popping a full queue.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 32'h10C + 32'(i) * 4, 1'b0, 1'b0);
        end
        checkOutput("full_count", count, 4);
        checkOutput("full_inReady", in_ready, 0);
        checkHead("full_lui", 32'h110, 32'h12345000, 3'd4, 1'b0);
        applyStimulus(1'b1, 32'h00A00513, 32'h1F0, 1'b1, 1'b0);
        checkOutput("fullPop_count", count, 3);
        checkOutput("fullPop_inReady", in_ready, 1);
        checkHead("full_beq", 32'h114, 32'hFFFFFFFC, 3'd3, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkHead("full_slli", 32'h118, 32'h00000005, 3'd6, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkHead("full_srai", 32'h11C, 32'h00000005, 3'd6, 1'b0);
        checkOutput("full_srai_funct7", out_funct7, 7'h20);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("full_drained", out_valid, 0);
        checkOutput("full_drainedCount", count, 0);
        applyStimulus(1'b1, 32'h00A00513, 32'h1F0, 1'b0, 1'b0);
        checkHead("full_retry", 32'h1F0, 32'h0000000A, 3'd1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Table: one instruction at a time through the empty queue.
        for (int i = 0; i < NVEC; i++) begin
            pcVal = 32'h200 + 32'(i) * 4;
            applyStimulus(1'b1, vecs[i].instr, pcVal, 1'b0, 1'b0);
            checkHead($sformatf("vec%0d", i), pcVal, vecs[i].imm, vecs[i].fmt, vecs[i].ill);
            checkOutput($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
            checkOutput($sformatf("vec%0d_opcode", i), out_opcode, vecs[i].instr[6:0]);
            checkOutput($sformatf("vec%0d_funct3", i), out_funct3, vecs[i].instr[14:12]);
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d_empty", i), out_valid, 0);
        end

        // Flush with a simultaneous push: everything is discarded.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 32'h300 + 32'(i) * 4, 1'b0, 1'b0);
        end
        checkOutput("flush_pre_count", count, 3);
        applyStimulus(1'b1, 32'h00A00513, 32'h3F0, 1'b1, 1'b1);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_outValid", out_valid, 0);
        checkOutput("flush_inReady", in_ready, 1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_stillEmpty", out_valid, 0);
        applyStimulus(1'b1, vecs[12].instr, 32'h400, 1'b0, 1'b0);
        checkHead("flush_after", 32'h400, 32'h00000004, 3'd1, 1'b0);
        checkOutput("flush_afterCount", count, 1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream must clear state before any edge.
        applyStimulus(1'b1, vecs[0].instr, 32'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, vecs[1].instr, 32'h504, 1'b0, 1'b0);
        checkOutput("arst_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_outValid", out_valid, 0);
        checkOutput("arst_count", count, 0);
        checkOutput("arst_inReady", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DEPTH+3 entries with stalls on both sides so the pointers wrap.
        expCount = 0;
        pushed   = 0;
        popped   = 0;
        for (int cyc = 0; cyc < 60 && popped < DEPTH + 3; cyc++) begin
            drvValid = (pushed < DEPTH + 3);
            drvReady = (cyc >= 4) && (cyc % 2 == 1);
            wantPush = drvValid && (expCount < DEPTH);
            wantPop  = drvReady && (expCount > 0);
            checkOutput("wrap_count", count, expCount);
            checkOutput("wrap_inReady", in_ready, expCount < DEPTH);
            if (wantPop) checkOutput("wrap_pc", out_pc, pcQ[0]);
            in_valid  = drvValid;
            in_instr  = 32'h00000013;
            in_pc     = 32'h1000 + 32'(pushed) * 4;
            out_ready = drvReady;
            @(posedge clk);
            #1;
            if (wantPush) begin
                pcQ.push_back(32'h1000 + 32'(pushed) * 4);
                pushed++;
            end
            if (wantPop) begin
                void'(pcQ.pop_front());
                popped++;
            end
            expCount = expCount + int'(wantPush) - int'(wantPop);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("wrap_drainedValid", out_valid, 0);
        checkOutput("wrap_drainedCount", count, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
